// File: rtl/reg_file_sb_pkg.sv
// Shared widths, tracker entry type and zero-register constant for reg_file_sb.
// Tracker entries carry a fixed-width address field so one type serves any ADDR_W up to 16.
package reg_file_sb_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_HAZ_DEPTH = 3;
    localparam int TRK_ADDR_W    = 16;
    localparam int ZERO_REG      = 0;

    typedef struct packed {
        logic                  valid;
        logic [TRK_ADDR_W-1:0] addr;
    } trk_entry_t;

endpackage

// File: rtl/reg_file_sb_track.sv
// In-flight destination tracker: shift register of {valid, addr}, per-port RAW compare, pending count.
// With REG_FILE_BYPASS_EN the last stage is writing back this cycle and is left out of the compare.
module reg_file_sb_track
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int HAZ_DEPTH = DEF_HAZ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        hazard,
    output logic                     stall,
    output logic [3:0]               pending_cnt
);

`ifdef REG_FILE_BYPASS_EN
    localparam int CMP_N = HAZ_DEPTH - 1;
`else
    localparam int CMP_N = HAZ_DEPTH;
`endif

    trk_entry_t stage [HAZ_DEPTH];
    logic       load;
    logic       exit_v;

    assign load   = issue_valid & ~stall & (issue_addr != ADDR_W'(ZERO_REG));
    assign exit_v = stage[HAZ_DEPTH-1].valid;
    assign stall  = |hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < HAZ_DEPTH; s++) stage[s] <= '0;
            pending_cnt <= '0;
        end else if (flush) begin
            for (int s = 0; s < HAZ_DEPTH; s++) stage[s] <= '0;
            pending_cnt <= '0;
        end else begin
            stage[0].valid <= load;
            stage[0].addr  <= TRK_ADDR_W'(issue_addr);
            for (int s = 1; s < HAZ_DEPTH; s++) stage[s] <= stage[s-1];
            if (load && !exit_v)
                pending_cnt <= pending_cnt + 4'd1;
            else if (!load && exit_v)
                pending_cnt <= pending_cnt - 4'd1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_cmp
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            hit = 1'b0;
            for (int s = 0; s < CMP_N; s++)
                if (stage[s].valid && (stage[s].addr == TRK_ADDR_W'(ra))) hit = 1'b1;
            if (ra == ADDR_W'(ZERO_REG)) hit = 1'b0;
        end

        assign hazard[k] = hit;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with scoreboard-style RAW hazard tracking; r0 is hardwired to zero.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int HAZ_DEPTH = DEF_HAZ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        hazard,
    output logic                     stall,
    output logic [3:0]               pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

    assign wr_ok = we && (wr_addr != ADDR_W'(ZERO_REG));

    // regs[0] is never written, so it holds its reset value of zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
        assign rd_data[k*DATA_W +: DATA_W] = (wr_ok && (ra == wr_addr)) ? wr_data : regs[ra];
`else
        assign rd_data[k*DATA_W +: DATA_W] = regs[ra];
`endif
    end

    reg_file_sb_track #(
        .ADDR_W    (ADDR_W),
        .NUM_RD    (NUM_RD),
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_track (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .rd_addr     (rd_addr),
        .hazard      (hazard),
        .stall       (stall),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (defaults: 32-bit data, 32 regs, 2 read ports, 3 tracker stages).
// Expectations adapt to REG_FILE_BYPASS_EN when the bench is built with it.
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [1:0]  hazard;
    logic        stall;
    logic [3:0]  pending_cnt;

    logic [4:0]  ra0, ra1;
    assign rd_addr = {ra1, ra0};

    reg_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .hazard      (hazard),
        .stall       (stall),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eh;
        logic [3:0]  ec;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act !== req) $display("FAIL %s: got %h want %h", nm, act, req);
        else n_pass++;
    endtask

    function automatic void add(input string nm, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd, input logic iv, input logic [4:0] ia,
                                input logic fl, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eh, input logic [3:0] ec);
        vec_t v;
        v.nm = nm; v.we = w; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia; v.fl = fl;
        v.ra0 = a0; v.ra1 = a1; v.e0 = e0; v.e1 = e1; v.eh = eh; v.ec = ec;
        vecs.push_back(v);
    endfunction

    task automatic idle();
        we = 0; wr_addr = 0; wr_data = 0; issue_valid = 0; issue_addr = 0;
        flush = 0; ra0 = 0; ra1 = 0;
    endtask

    initial begin
        vec_t e;
        // name        we wa  wd            iv ia  fl ra0 ra1 exp rd0        exp rd1         haz         cnt
        add("reset",    0, 0, 32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("wr_r5",    1, 5, 32'hDEADBEEF, 0, 0,  0, 5,  5,  BYP ? 32'hDEADBEEF : 32'h0,
                                                              BYP ? 32'hDEADBEEF : 32'h0,   2'b00,      4'd0);
        add("rd_r5",    0, 0, 32'h0,        0, 0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF,   2'b00,      4'd0);
        add("wr_r0",    1, 0, 32'h1,        0, 0,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("rd_r0",    0, 0, 32'h0,        0, 0,  0, 0,  5,  32'h0,        32'hDEADBEEF,   2'b00,      4'd0);
        add("iss_r7",   0, 0, 32'h0,        1, 7,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("haz_c1",   0, 0, 32'h0,        0, 0,  0, 7,  0,  32'h0,        32'h0,          2'b01,      4'd1);
        add("haz_c2",   0, 0, 32'h0,        0, 0,  0, 7,  0,  32'h0,        32'h0,          2'b01,      4'd1);
        add("haz_c3",   0, 0, 32'h0,        0, 0,  0, 7,  0,  32'h0,        32'h0,
                                                              BYP ? 2'b00 : 2'b01,                  4'd1);
        add("haz_gone", 0, 0, 32'h0,        0, 0,  0, 7,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("iss_r7b",  0, 0, 32'h0,        1, 7,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("hold_r9a", 0, 0, 32'h0,        1, 9,  0, 7,  9,  32'h0,        32'h0,          2'b01,      4'd1);
        add("hold_r9b", 0, 0, 32'h0,        1, 9,  0, 7,  9,  32'h0,        32'h0,          2'b01,      4'd1);
        add("hold_end", 0, 0, 32'h0,        0, 0,  0, 7,  9,  32'h0,        32'h0,
                                                              BYP ? 2'b00 : 2'b01,                  4'd1);
        add("no_r9",    0, 0, 32'h0,        0, 0,  0, 7,  9,  32'h0,        32'h0,          2'b00,      4'd0);
        add("b2b_r3",   0, 0, 32'h0,        1, 3,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("b2b_r4",   0, 0, 32'h0,        1, 4,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd1);
        add("b2b_r6",   0, 0, 32'h0,        1, 6,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd2);
        add("b2b_r10",  0, 0, 32'h0,        1, 10, 0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd3);
        add("drain3",   0, 0, 32'h0,        0, 0,  0, 10, 4,  32'h0,        32'h0,
                                                              BYP ? 2'b01 : 2'b11,                  4'd3);
        add("drain2",   0, 0, 32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd2);
        add("drain1",   0, 0, 32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd1);
        add("drain0",   0, 0, 32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("fl_r3",    0, 0, 32'h0,        1, 3,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd0);
        add("fl_r4",    0, 0, 32'h0,        1, 4,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd1);
        add("fl_r6",    0, 0, 32'h0,        1, 6,  0, 0,  0,  32'h0,        32'h0,          2'b00,      4'd2);
        add("flush",    0, 0, 32'h0,        1, 11, 1, 6,  4,  32'h0,        32'h0,          2'b11,      4'd3);
        add("post_fl",  0, 0, 32'h0,        0, 0,  0, 6,  11, 32'h0,        32'h0,          2'b00,      4'd0);
        add("wr_r12",   1, 12, 32'hA5A5A5A5, 0, 0, 0, 0,  12, 32'h0,
                                              BYP ? 32'hA5A5A5A5 : 32'h0,                   2'b00,      4'd0);
        add("rd_r12",   0, 0, 32'h0,        0, 0,  0, 5,  12, 32'hDEADBEEF, 32'hA5A5A5A5,   2'b00,      4'd0);

        rst = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst.cnt",   64'(pending_cnt), 64'd0);
        chk("rst.stall", 64'(stall),       64'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            we = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            issue_valid = vecs[i].iv; issue_addr = vecs[i].ia; flush = vecs[i].fl;
            ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            exp_q.push_back(vecs[i]);
            #1;
            e = exp_q.pop_front();
            chk({e.nm, ".rd0"},   64'(rd_data[31:0]),  64'(e.e0));
            chk({e.nm, ".rd1"},   64'(rd_data[63:32]), 64'(e.e1));
            chk({e.nm, ".haz"},   64'(hazard),         64'(e.eh));
            chk({e.nm, ".stall"}, 64'(stall),          64'(|e.eh));
            chk({e.nm, ".cnt"},   64'(pending_cnt),    64'(e.ec));
        end

        // mid-run reset with r5 holding data and two destinations in flight
        @(negedge clk);
        idle(); issue_valid = 1; issue_addr = 20;
        @(negedge clk);
        issue_addr = 21;
        @(negedge clk);
        idle(); ra0 = 20; ra1 = 5;
        #1;
        chk("pre_rst.haz", 64'(hazard),          64'd1);
        chk("pre_rst.cnt", 64'(pending_cnt),     64'd2);
        chk("pre_rst.rd1", 64'(rd_data[63:32]),  64'hDEADBEEF);
        #1 rst = 1'b0;
        #1;
        chk("async_rst.rd1",   64'(rd_data[63:32]), 64'd0);
        chk("async_rst.stall", 64'(stall),          64'd0);
        chk("async_rst.haz",   64'(hazard),         64'd0);
        chk("async_rst.cnt",   64'(pending_cnt),    64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst.rd1", 64'(rd_data[63:32]), 64'd0);
        chk("post_rst.cnt", 64'(pending_cnt),    64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 Parameter ADDR_W, default 5, SHALL set the register address width; the file depth is 2^ADDR_W.
REQ-004 Parameter NUM_RD, default 2, SHALL set the number of read ports.
REQ-005 Parameter HAZ_DEPTH, default 3, SHALL set the number of in-flight destination tracker stages (legal range 1..8).
REQ-006 The block SHALL have these ports, as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed combinational read data.
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- issue_valid  in  1  a writing instruction is requesting issue.
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  synchronous clear of all tracker entries.
- hazard  out  NUM_RD  per-port RAW hazard flag.
- stall  out  1  OR of hazard.
- pending_cnt  out  4  number of valid tracker entries.

Function
REQ-007 Register 0 SHALL read as 0 at all times; writes to address 0 SHALL be ignored.
REQ-008 When we=1 and wr_addr!=0, wr_data SHALL be written on the rising clk edge.
REQ-009 rd_data port k SHALL be the combinational value of the register at rd_addr port k.
REQ-010 The tracker SHALL be a HAZ_DEPTH-stage shift register of {valid, addr} entries that advances on every clk edge.
REQ-011 Stage 0 SHALL load valid = issue_valid & ~stall & (issue_addr!=0) and addr = issue_addr; otherwise it SHALL load a bubble (valid=0).
REQ-012 The entry leaving the last stage SHALL be discarded.
REQ-013 hazard[k] SHALL be 1 iff rd_addr port k != 0 and it matches the addr of any valid tracker stage, subject to REQ-020.
REQ-014 stall SHALL equal the OR-reduction of hazard.
REQ-015 stall SHALL be combinational, with zero-cycle latency from rd_addr and the tracker.
REQ-016 pending_cnt SHALL equal the count of valid tracker entries, maintained as a registered counter: +1 on load, -1 when a valid entry exits, unchanged when both occur.
REQ-017 When flush=1 at an edge, all tracker valids SHALL clear and pending_cnt SHALL become 0; flush SHALL have priority over issue.
REQ-018 A register write and a tracker shift in the same cycle SHALL be independent; neither blocks the other.

Reset
REQ-019 While rst=0, all registers SHALL be 0, all tracker valids 0, and pending_cnt 0; hazard and stall SHALL therefore be 0. Reset asserted mid-operation SHALL discard pending entries immediately, without waiting for a clock edge.

Configuration
REQ-020 With macro REG_FILE_BYPASS_EN defined:
- a read whose address equals wr_addr, while we=1 and wr_addr!=0, SHALL return wr_data in the same cycle;
- the last tracker stage SHALL be excluded from the hazard comparison.
Without the macro, reads SHALL return stored values only, and all HAZ_DEPTH stages SHALL be compared.

Structure
REQ-021 The shared package SHALL hold the default widths, the tracker entry typedef {valid, addr}, and the zero-register constant.
REQ-022 The tracker shift register, its comparators, and pending_cnt SHALL form the sub-module reg_file_sb_track, instantiated once; the per-port compare SHALL be generated NUM_RD times.

Verification
REQ-023 The bench SHALL cover these directed scenarios, as stimulus -> required response:
- Write 32'hDEADBEEF to r5, next cycle read r5 on both ports -> rd_data = DEADBEEF on both; write 32'h1 to r0, read r0 -> 0.
- Issue dest r7, next cycle read rd_addr0=7 -> hazard=2'b01, stall=1 for 3 cycles (HAZ_DEPTH=3, no bypass); 2 cycles with REG_FILE_BYPASS_EN.
- Hold issue_valid=1 with issue_addr=9 while stall=1 from r7 -> no r9 entry loaded; pending_cnt does not increase.
- Issue r3, r4, r6 back-to-back -> pending_cnt goes 1, 2, 3, then 3 while issuing continues and 2, 1, 0 once issuing stops.
- Assert flush with 3 entries pending -> pending_cnt=0 and hazard=0 next cycle; issue in the flush cycle is dropped.
- Assert rst low mid-run with r5 holding data and 2 entries pending -> r5 reads 0 and stall=0 without a clock edge.
- With REG_FILE_BYPASS_EN, we=1, wr_addr=12, wr_data=32'hA5A5A5A5, rd_addr1=12 in the same cycle -> rd_data port 1 = A5A5A5A5.
